pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor with carry-in, carry-out and signed-overflow flag. It is the sequential successor to our small combinational 2-bit add benchmarks. The operand width is split into STAGES equal chunks, and one chunk is resolved per pipeline stage, with the carry passed between stages in registers. A valid/ready handshake on both sides gives one operation per cycle of throughput and full backpressure. It is used as a datapath primitive and as a benchmark netlist source.

Parameters:
WIDTH, 8, operand/result width in bits; must be at least 2.
STAGES, 2, number of pipeline stages; must divide WIDTH exactly; CHUNK = WIDTH/STAGES.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand set is presented
in_ready  out  1  block accepts operands this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (borrow-in when subtracting)
op_sub  in  1  0 = A+B+cin; 1 = A-B-cin
out_valid  out  1  result is presented
out_ready  in  1  downstream accepts the result
sum  out  WIDTH  result bits
cout  out  1  carry out of the MSB (when subtracting, 1 = no borrow)
ovf  out  1  signed overflow

Behaviour:
- Reset (async assert, sync release on the clk edge): every stage valid flag = 0, every data/carry register = 0. Therefore out_valid=0, sum=0, cout=0, ovf=0, and in_ready=1.
- Operand transform at input:
  - b_eff = op_sub ? ~b : b
  - c0 = cin XOR op_sub
  - Add: A+B+cin. Sub: A+~B+1-cin = A-B-cin.
- Stage k (k = 0..STAGES-1):
  - Computes chunk bits [k*CHUNK +: CHUNK] of a + b_eff plus the carry registered from stage k-1 (c0 for stage 0).
  - Registers the partial sum and the carry-out of the chunk.
  - Forwards the still-unprocessed high chunks of a and b_eff unchanged.
- Last stage computes cout and ovf:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. The carry into the MSB is captured in the last stage.
- Latency: an operand accepted at edge N produces out_valid=1 after edge N+STAGES-1, i.e. the result registers load at edge N+STAGES-1. For STAGES=1 the result is visible the cycle after acceptance.
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - Global stall: stall = out_valid & ~out_ready; in_ready = ~stall.
  - While stalled, every pipeline register (data, carry, valid) holds its value. sum/cout/ovf stay stable while out_valid=1 and out_ready=0.
  - With no stall the pipeline advances every cycle. Bubbles (valid=0) propagate; data in bubble slots is don't-care, but out_valid must stay 0 for them.
  - Back-to-back accepts give one result per cycle. Ordering is strictly FIFO, with no drops and no duplicates.
- Simultaneous output and input transfer in the same cycle is legal. The pipeline shifts and the new operand enters stage 0.
- in_ready must not combinationally depend on in_valid.
- Operands and op_sub are sampled only on an input transfer; they may change freely otherwise.
- Reset mid-operation: all in-flight operations are discarded immediately and asynchronously. No result from before reset ever appears after release.
- Width rules: all arithmetic is modulo 2^WIDTH. The chunk carry is 1 bit. There is no saturation.

Test Plan:
- WIDTH=8, STAGES=2, add, a=0x7F, b=0x01, cin=0 -> after 2 cycles: sum=0x80, cout=0, ovf=1.
- Add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Separately, a=0x0F, b=0x00, cin=1 -> sum=0x10 (carry crosses the chunk boundary), cout=0.
- Sub, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0, ovf=0. Sub, a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, ovf=1. Sub with cin=1, a=0x10, b=0x01 -> sum=0x0E.
- Backpressure: stream 6 back-to-back operations (a=i, b=i, i=1..6) with out_ready low for cycles 3-5 -> in_ready=0 during the stall, outputs held stable, results 2,4,6,8,10,12 delivered in order with none lost.
- Assert rst_n=0 with 2 operations in flight, release, then idle -> out_valid=0 immediately and for all following cycles; the first post-reset operand 0x01+0x01 returns 0x02.
- Configuration sweep:
  - WIDTH=2, STAGES=1: a=3, b=3, cin=1 -> sum=3, cout=1, one cycle of latency.
  - WIDTH=16, STAGES=4: 0xFFFF+0x0001 -> 0x0000, cout=1, after 4 cycles.
  - Random self-checking comparison against a behavioural model at full throughput with random out_ready.

Source files
------------

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined two's-complement adder/subtractor with valid/ready handshake
//
// The operands are split into STAGES chunks of CHUNK = WIDTH/STAGES bits (WIDTH >= 2,
// STAGES must divide WIDTH). Stage k adds chunk k using the carry registered by stage k-1,
// so the carry chain per cycle is only CHUNK bits long. Stage 0 works directly on the
// input port, which gives a latency of STAGES register loads from acceptance to result.
// A single global stall (result presented but not taken) freezes every stage.
module pipelined_addsub #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;

   // Subtraction is A + ~B + 1 - cin, so B is inverted and the carry-in flipped once at entry.
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic             stall;

   assign b_eff    = op_sub ? ~b : b;
   assign c0       = cin ^ op_sub;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * CHUNK;    // lowest bit resolved by this stage
      localparam int HI = LO + CHUNK;   // lowest bit left for later stages

      logic             v_in;
      logic             c_in;
      logic [CHUNK-1:0] a_ch;
      logic [CHUNK-1:0] b_ch;
      logic [CHUNK:0]   part;
      logic [HI-1:0]    s_next;

      logic             v_r;
      logic             c_r;
      logic [HI-1:0]    s_r;            // result bits resolved so far

      if (k == 0) begin : g_src
         assign v_in   = in_valid;
         assign c_in   = c0;
         assign a_ch   = a[HI-1:LO];
         assign b_ch   = b_eff[HI-1:LO];
         assign s_next = part[CHUNK-1:0];
      end else begin : g_src
         assign v_in   = g_st[k-1].v_r;
         assign c_in   = g_st[k-1].c_r;
         assign a_ch   = g_st[k-1].g_fwd.a_r[HI-1:LO];
         assign b_ch   = g_st[k-1].g_fwd.b_r[HI-1:LO];
         assign s_next = {part[CHUNK-1:0], g_st[k-1].s_r};
      end

      // Chunk adder; the extra top bit is the carry handed to the next stage.
      assign part = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_in};

      // Stage register: valid always follows the upstream slot, data only loads for real operands.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_r <= 1'b0;
            c_r <= 1'b0;
            s_r <= '0;
         end else if (!stall) begin
            v_r <= v_in;
            if (v_in) begin
               c_r <= part[CHUNK];
               s_r <= s_next;
            end
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [WIDTH-1:HI] a_hi;
         logic [WIDTH-1:HI] b_hi;
         logic [WIDTH-1:HI] a_r;
         logic [WIDTH-1:HI] b_r;

         if (k == 0) begin : g_hsrc
            assign a_hi = a[WIDTH-1:HI];
            assign b_hi = b_eff[WIDTH-1:HI];
         end else begin : g_hsrc
            assign a_hi = g_st[k-1].g_fwd.a_r[WIDTH-1:HI];
            assign b_hi = g_st[k-1].g_fwd.b_r[WIDTH-1:HI];
         end

         // Carry the still-unprocessed high operand chunks alongside this stage's result.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_r <= '0;
               b_r <= '0;
            end else if (!stall && v_in) begin
               a_r <= a_hi;
               b_r <= b_hi;
            end
         end
      end

      if (k == STAGES - 1) begin : g_ovf
         logic ovf_r;

         // Carry into the MSB is a^b^sum at that bit; overflow is it XOR the carry out.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_r <= 1'b0;
            end else if (!stall && v_in) begin
               ovf_r <= a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ part[CHUNK-1] ^ part[CHUNK];
            end
         end
      end
   end

   assign out_valid = g_st[STAGES-1].v_r;
   assign sum       = g_st[STAGES-1].s_r;
   assign cout      = g_st[STAGES-1].c_r;
   assign ovf       = g_st[STAGES-1].g_ovf.ovf_r;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - directed and random checks of pipelined_addsub in three configurations
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout, ovf;
   logic [7:0]  a, b, sum;

   logic        d2_in_valid, d2_in_ready, d2_cin, d2_op_sub, d2_out_valid, d2_out_ready, d2_cout, d2_ovf;
   logic [1:0]  d2_a, d2_b, d2_sum;

   logic        d16_in_valid, d16_in_ready, d16_cin, d16_op_sub, d16_out_valid, d16_out_ready, d16_cout, d16_ovf;
   logic [15:0] d16_a, d16_b, d16_sum;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_out;
   logic [9:0]  exp_q [$];
   logic        was_stall;
   logic [9:0]  held;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .op_sub(op_sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   pipelined_addsub #(.WIDTH(2), .STAGES(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
      .a(d2_a), .b(d2_b), .cin(d2_cin), .op_sub(d2_op_sub),
      .out_valid(d2_out_valid), .out_ready(d2_out_ready), .sum(d2_sum), .cout(d2_cout), .ovf(d2_ovf)
   );

   pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
      .a(d16_a), .b(d16_b), .cin(d16_cin), .op_sub(d16_op_sub),
      .out_valid(d16_out_valid), .out_ready(d16_out_ready), .sum(d16_sum), .cout(d16_cout), .ovf(d16_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural 8-bit reference, returns {ovf, cout, sum}.
   function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci, input logic sub);
      int         ux, uy, sx, sy, r, sr;
      logic       co, ov;
      logic [7:0] s;
      ux = int'(x);
      uy = int'(y);
      sx = x[7] ? ux - 256 : ux;
      sy = y[7] ? uy - 256 : uy;
      if (sub) begin
         r  = ux - uy - int'(ci);
         sr = sx - sy - int'(ci);
         co = (r >= 0);
      end else begin
         r  = ux + uy + int'(ci);
         sr = sx + sy + int'(ci);
         co = (r > 255);
      end
      s  = 8'(r);
      ov = (sr > 127) || (sr < -128);
      return {ov, co, s};
   endfunction

   // Called at the negedge: hold check, output scoreboard, then record any accepted operand.
   task automatic mon(input string tag);
      logic [9:0] e;
      if (was_stall) begin
         check({tag, " hold valid"}, out_valid, 1);
         check({tag, " hold data"}, {ovf, cout, sum}, held);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check({tag, " spurious out"}, out_valid, 0);
         end else begin
            e = exp_q.pop_front();
            check({tag, " result"}, {ovf, cout, sum}, e);
            n_out++;
         end
      end
      if (in_valid && in_ready) exp_q.push_back(model8(a, b, cin, op_sub));
      was_stall = out_valid && !out_ready;
      held      = {ovf, cout, sum};
   endtask

   // Single operation through the 8-bit/2-stage instance; entered and left 1 time unit after a posedge.
   task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic ts,
                        input logic [7:0] es, input logic ec, input logic eo);
      a = ta; b = tb_v; cin = tc; op_sub = ts; in_valid = 1'b1;
      check({tag, " in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
      check({tag, " latency"}, out_valid, 0);
      @(posedge clk); #1;
      check({tag, " valid"}, out_valid, 1);
      check({tag, " sum"}, sum, es);
      check({tag, " cout"}, cout, ec);
      check({tag, " ovf"}, ovf, eo);
      @(posedge clk); #1;
   endtask

   task automatic do16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tc, input logic ts,
                       input logic [15:0] es, input logic ec, input logic eo);
      d16_a = ta; d16_b = tb_v; d16_cin = tc; d16_op_sub = ts; d16_in_valid = 1'b1;
      @(posedge clk); #1;
      d16_in_valid = 1'b0;
      d16_a = 16'($urandom);
      repeat (2) begin @(posedge clk); #1; end
      check({tag, " latency"}, d16_out_valid, 0);
      @(posedge clk); #1;
      check({tag, " valid"}, d16_out_valid, 1);
      check({tag, " sum"}, d16_sum, es);
      check({tag, " cout"}, d16_cout, ec);
      check({tag, " ovf"}, d16_ovf, eo);
      @(posedge clk); #1;
   endtask

   initial begin
      int idx;
      rst_n = 1'b0;
      in_valid = 0; a = 0; b = 0; cin = 0; op_sub = 0; out_ready = 1;
      d2_in_valid = 0; d2_a = 0; d2_b = 0; d2_cin = 0; d2_op_sub = 0; d2_out_ready = 1;
      d16_in_valid = 0; d16_a = 0; d16_b = 0; d16_cin = 0; d16_op_sub = 0; d16_out_ready = 1;
      was_stall = 0; held = 0; n_out = 0;

      #12;
      check("reset out_valid", out_valid, 0);
      check("reset sum", sum, 0);
      check("reset cout", cout, 0);
      check("reset ovf", ovf, 0);
      check("reset in_ready", in_ready, 1);
      check("reset d16 out_valid", d16_out_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("add 7f+01",    8'h7f, 8'h01, 0, 0, 8'h80, 0, 1);
      do_op("add ff+01",    8'hff, 8'h01, 0, 0, 8'h00, 1, 0);
      do_op("add 0f+00+1",  8'h0f, 8'h00, 1, 0, 8'h10, 0, 0);
      do_op("add 80+80",    8'h80, 8'h80, 0, 0, 8'h00, 1, 1);
      do_op("add ff+ff+1",  8'hff, 8'hff, 1, 0, 8'hff, 1, 0);
      do_op("sub 05-07",    8'h05, 8'h07, 0, 1, 8'hfe, 0, 0);
      do_op("sub 80-01",    8'h80, 8'h01, 0, 1, 8'h7f, 1, 1);
      do_op("sub 10-01-1",  8'h10, 8'h01, 1, 1, 8'h0e, 1, 0);
      do_op("sub 00-00",    8'h00, 8'h00, 0, 1, 8'h00, 1, 0);
      do_op("sub 7f-ff",    8'h7f, 8'hff, 0, 1, 8'h80, 0, 1);

      // Backpressure: six back-to-back operands, result side stalled in cycles 3..5.
      idx = 0; n_out = 0; was_stall = 0; exp_q.delete();
      for (int c = 0; c < 20; c++) begin
         in_valid = (idx < 6);
         a = 8'(idx + 1); b = 8'(idx + 1); cin = 0; op_sub = 0;
         out_ready = !(c >= 3 && c <= 5);
         @(negedge clk);
         if (c >= 3 && c <= 5) check("bp in_ready low", in_ready, 0);
         if (c >= 3 && c <= 5) check("bp out_valid held", out_valid, 1);
         if (in_valid && in_ready) idx++;
         mon("bp");
         @(posedge clk); #1;
      end
      in_valid = 0; out_ready = 1;
      check("bp delivered", n_out, 6);
      check("bp queue empty", exp_q.size(), 0);

      // Reset with two operations in flight.
      a = 8'h03; b = 8'h04; cin = 0; op_sub = 0; in_valid = 1;
      @(posedge clk); #1;
      a = 8'h05; b = 8'h06;
      @(posedge clk); #1;
      in_valid = 0;
      check("pre-reset out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("async reset out_valid", out_valid, 0);
      check("async reset sum", sum, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post-reset idle", out_valid, 0);
         @(posedge clk); #1;
      end
      do_op("post-reset 01+01", 8'h01, 8'h01, 0, 0, 8'h02, 0, 0);

      // Random traffic against the reference model with random backpressure.
      n_out = 0; was_stall = 0; exp_q.delete();
      for (int c = 0; c < 300; c++) begin
         in_valid  = ($urandom_range(0, 7) != 0);
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         mon("rnd");
         @(posedge clk); #1;
      end
      in_valid = 0; out_ready = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         mon("drain");
         @(posedge clk); #1;
      end
      check("rnd queue empty", exp_q.size(), 0);
      check("rnd some results", (n_out > 100), 1);

      // WIDTH=2, STAGES=1: one cycle of latency.
      d2_a = 2'd3; d2_b = 2'd3; d2_cin = 1; d2_op_sub = 0; d2_in_valid = 1;
      check("w2 in_ready", d2_in_ready, 1);
      @(posedge clk); #1;
      d2_in_valid = 0;
      check("w2 add valid", d2_out_valid, 1);
      check("w2 add sum", d2_sum, 3);
      check("w2 add cout", d2_cout, 1);
      check("w2 add ovf", d2_ovf, 0);
      d2_a = 2'd2; d2_b = 2'd1; d2_cin = 0; d2_op_sub = 1; d2_in_valid = 1;
      @(posedge clk); #1;
      d2_in_valid = 0;
      check("w2 sub sum", d2_sum, 1);
      check("w2 sub cout", d2_cout, 1);
      check("w2 sub ovf", d2_ovf, 1);
      @(posedge clk); #1;
      check("w2 bubble", d2_out_valid, 0);

      // WIDTH=16, STAGES=4.
      do16("w16 ffff+1",    16'hffff, 16'h0001, 0, 0, 16'h0000, 1, 0);
      do16("w16 0fff+1",    16'h0fff, 16'h0001, 0, 0, 16'h1000, 0, 0);
      do16("w16 8000-1",    16'h8000, 16'h0001, 0, 1, 16'h7fff, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
